// File: rtl/tank_pkg.sv
// Shared types and constants for the tank renderer: colours, directions,
// grid geometry defaults and the tank descriptor.
package tank_pkg;

  localparam int unsigned COORD_W    = 11;
  localparam int unsigned GRID_W     = 5;
  localparam int unsigned RGB_W      = 12;
  localparam int unsigned CELL_DEF   = 20;
  localparam int unsigned ORIGIN_DEF = 80;

  localparam logic [RGB_W-1:0] COLOR_PLAYER = 12'h00F;
  localparam logic [RGB_W-1:0] COLOR_ENEMY  = 12'hF00;
  localparam logic [RGB_W-1:0] COLOR_NONE   = 12'h000;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef struct packed {
    logic [GRID_W-1:0] x;
    logic [GRID_W-1:0] y;
    logic              state;
    dir_t              dir;
  } tank_desc_t;

  // Strict window c-below < v < c+above, evaluated one bit wider so nothing wraps.
  function automatic logic in_rng(logic [COORD_W-1:0] v, logic [COORD_W-1:0] c,
                                  int unsigned below, int unsigned above);
    logic [COORD_W:0] vw;
    logic [COORD_W:0] cw;
    vw = {1'b0, v};
    cw = {1'b0, c};
    return ((vw + (COORD_W+1)'(below)) > cw) && (vw < (cw + (COORD_W+1)'(above)));
  endfunction

endpackage

// File: rtl/tank_render_ctrl_if.sv
// Pixel, control and descriptor-update signals between game logic / VGA
// timing and the tank renderer.
interface tank_render_ctrl_if #(
  parameter int unsigned N_TANKS = 4
);
  import tank_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_TANKS);

  logic                 enable;
  logic                 frame_start;
  logic [COORD_W-1:0]   VGA_xpos;
  logic [COORD_W-1:0]   VGA_ypos;
  logic                 upd_req;
  logic [IDX_W-1:0]     upd_idx;
  logic [GRID_W-1:0]    upd_x;
  logic [GRID_W-1:0]    upd_y;
  logic                 upd_state;
  logic [1:0]           upd_dir;
  logic                 upd_ack;
  logic [RGB_W-1:0]     VGA_data;
  logic                 hit_valid;
  logic [IDX_W-1:0]     hit_idx;

  modport master (
    output enable, frame_start, VGA_xpos, VGA_ypos,
    output upd_req, upd_idx, upd_x, upd_y, upd_state, upd_dir,
    input  upd_ack, VGA_data, hit_valid, hit_idx
  );

  modport slave (
    input  enable, frame_start, VGA_xpos, VGA_ypos,
    input  upd_req, upd_idx, upd_x, upd_y, upd_state, upd_dir,
    output upd_ack, VGA_data, hit_valid, hit_idx
  );

endinterface

// File: rtl/tank_shape_hit.sv
// Combinational shape test: does pixel (xpos,ypos) fall on the barrel or
// body of one tank descriptor?
module tank_shape_hit
  import tank_pkg::*;
#(
  parameter int unsigned CELL   = CELL_DEF,
  parameter int unsigned ORIGIN = ORIGIN_DEF
) (
  input  tank_desc_t          desc,
  input  logic [COORD_W-1:0]  xpos,
  input  logic [COORD_W-1:0]  ypos,
  output logic                hit_c
);

  logic [COORD_W-1:0] cx;
  logic [COORD_W-1:0] cy;
  logic               barrel;
  logic               body;

  assign cx = COORD_W'(desc.x) * COORD_W'(CELL) + COORD_W'(ORIGIN);
  assign cy = COORD_W'(desc.y) * COORD_W'(CELL) + COORD_W'(ORIGIN);

  // Barrel is a 10-wide stub on the facing side; body fills the opposite half.
  always_comb begin
    barrel = 1'b0;
    body   = 1'b0;
    unique case (desc.dir)
      DIR_UP: begin
        barrel = in_rng(xpos, cx, 5, 5)   && in_rng(ypos, cy, 10, 0);
        body   = in_rng(xpos, cx, 10, 10) && in_rng(ypos, cy, 0, 10);
      end
      DIR_DOWN: begin
        body   = in_rng(xpos, cx, 10, 10) && in_rng(ypos, cy, 10, 0);
        barrel = in_rng(xpos, cx, 5, 5)   && in_rng(ypos, cy, 0, 10);
      end
      DIR_LEFT: begin
        barrel = in_rng(xpos, cx, 10, 0)  && in_rng(ypos, cy, 5, 5);
        body   = in_rng(xpos, cx, 0, 10)  && in_rng(ypos, cy, 10, 10);
      end
      DIR_RIGHT: begin
        body   = in_rng(xpos, cx, 10, 0)  && in_rng(ypos, cy, 10, 10);
        barrel = in_rng(xpos, cx, 0, 10)  && in_rng(ypos, cy, 5, 5);
      end
      default: begin
        barrel = 1'b0;
        body   = 1'b0;
      end
    endcase
    hit_c = desc.state && (barrel || body);
  end

endmodule

// File: rtl/tank_render_ctrl.sv
// Tank render scheduler: shadow/live descriptor tables with frame-start copy,
// req/ack write port, and a 2-stage per-pixel hit/priority pipeline.
module tank_render_ctrl
  import tank_pkg::*;
#(
  parameter int unsigned N_TANKS = 4,
  parameter int unsigned CELL    = CELL_DEF,
  parameter int unsigned ORIGIN  = ORIGIN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  tank_render_ctrl_if.slave    bus
);

  localparam int unsigned IDX_W = $clog2(N_TANKS);

  typedef enum logic {ST_RUN, ST_COPY} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 copy_en_c;
  logic                 wr_en_c;
  tank_desc_t           wr_desc_c;
  tank_desc_t           shadow_q [N_TANKS];
  tank_desc_t           live_q   [N_TANKS];
  logic [N_TANKS-1:0]   hit_c;
  logic [N_TANKS-1:0]   hit_q;
  logic                 win_valid_c;
  logic [IDX_W-1:0]     win_idx_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writes are only taken in RUN and never on the frame_start cycle, so a
  // copy always sees a stable shadow table.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    copy_en_c = 1'b0;
    wr_en_c   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.frame_start) begin
          state_d = ST_COPY;
          cnt_d   = '0;
        end else if (bus.upd_req && !bus.upd_ack) begin
          wr_en_c = 1'b1;
        end
      end
      ST_COPY: begin
        copy_en_c = 1'b1;
        cnt_d     = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(N_TANKS - 1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign wr_desc_c = '{x: bus.upd_x, y: bus.upd_y, state: bus.upd_state,
                       dir: dir_t'(bus.upd_dir)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_TANKS); i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
      bus.upd_ack <= 1'b0;
    end else begin
      if (wr_en_c)   shadow_q[bus.upd_idx] <= wr_desc_c;
      if (copy_en_c) live_q[cnt_q]         <= shadow_q[cnt_q];
      bus.upd_ack <= wr_en_c;
    end
  end

  for (genvar g = 0; g < int'(N_TANKS); g++) begin : g_shape
    tank_shape_hit #(.CELL(CELL), .ORIGIN(ORIGIN)) u_shape (
      .desc  (live_q[g]),
      .xpos  (bus.VGA_xpos),
      .ypos  (bus.VGA_ypos),
      .hit_c (hit_c[g])
    );
  end

  // Lowest slot wins so the player tank is drawn over enemies.
  always_comb begin
    win_valid_c = |hit_q;
    win_idx_c   = '0;
    for (int i = int'(N_TANKS) - 1; i >= 0; i--) begin
      if (hit_q[i]) win_idx_c = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q         <= '0;
      bus.hit_valid <= 1'b0;
      bus.hit_idx   <= '0;
      bus.VGA_data  <= COLOR_NONE;
    end else begin
      hit_q         <= bus.enable ? hit_c : '0;
      bus.hit_valid <= win_valid_c;
      bus.hit_idx   <= win_idx_c;
      if (!win_valid_c)           bus.VGA_data <= COLOR_NONE;
      else if (win_idx_c == '0)   bus.VGA_data <= COLOR_PLAYER;
      else                        bus.VGA_data <= COLOR_ENEMY;
    end
  end

endmodule
